spike_popcount_accum: RTL and testbench

Pipelined, parametrised spike popcount and accumulator for the attention-calculation path. Each beat carries a SPIKE_W-bit spike word. The block counts the ones in each beat using 8-input full-adder compressor groups followed by an adder tree. It then accumulates those counts across a multi-beat frame delimited by a last flag and presents one frame sum per frame on a valid/ready output. This replaces fixed 8-bit combinational counting wherever Q·K/attention sums span wider vectors or multiple beats.

---
 rtl/spike_popcount_accum.sv | 169 ++++++++++++++++
 tb/tb_spike_popcount_accum.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_popcount_accum.sv
// Pipelined spike popcount (8-bit compressor groups + adder tree) with per-frame accumulation.
// Optional frame-sum saturation and sticky saturation flag: define POPCNT_SAT_EN.
module spike_popcount_accum #(
   parameter int unsigned SPIKE_W = 64,
   parameter int unsigned ACC_W   = 16
) (
   input  logic               s_clk,
   input  logic               s_rst_n,
   input  logic               i_spikes_valid,
   input  logic [SPIKE_W-1:0] i_spikes_data,
   input  logic               i_spikes_last,
   output logic               o_spikes_ready,
   output logic               o_sum_valid,
   output logic [ACC_W-1:0]   o_sum,
   output logic               o_sum_sat,
   input  logic               i_sum_ready
);
   localparam int unsigned CNT_W = $clog2(SPIKE_W + 1);
   localparam int unsigned N_GRP = SPIKE_W / 8;
   localparam int unsigned SUM_W = ACC_W + 1;

   // {carry, sum} of a single full adder
   function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
      return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
   endfunction

   // 8-input compressor: three FAs at weight 1, one FA at weight 2, half adders close each column
   function automatic logic [3:0] popcnt8(input logic [7:0] b);
      logic [1:0] fa1;
      logic [1:0] fa2;
      logic [1:0] fa3;
      logic [1:0] fa4;
      logic       h1;
      logic       h2;
      fa1 = full_add(b[0], b[1], b[2]);
      fa2 = full_add(b[3], b[4], b[5]);
      fa3 = full_add(fa1[0], fa2[0], b[6]);
      fa4 = full_add(fa1[1], fa2[1], fa3[1]);
      h1  = fa3[0] & b[7];
      h2  = fa4[0] & h1;
      return {fa4[1] & h2, fa4[1] ^ h2, fa4[0] ^ h1, fa3[0] ^ b[7]};
   endfunction

   logic en;
   logic accept;

   // A pending result that downstream refuses freezes the whole pipe
   assign en             = !(o_sum_valid && !i_sum_ready);
   assign o_spikes_ready = en;
   assign accept         = i_spikes_valid && en;

   // Stage 1: per-byte group counts
   logic [N_GRP-1:0][3:0] grp_cnt;
   logic [N_GRP-1:0][3:0] cnt1;
   logic                  v1;
   logic                  last1;

   always_comb begin
      grp_cnt = '0;
      for (int g = 0; g < N_GRP; g++) begin
         grp_cnt[g] = popcnt8(i_spikes_data[8*g +: 8]);
      end
   end

   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         v1    <= 1'b0;
         last1 <= 1'b0;
         cnt1  <= '0;
      end else if (en) begin
         v1    <= accept;
         last1 <= i_spikes_last;
         if (accept) cnt1 <= grp_cnt;
      end
   end

   // Stage 2: reduce the group counts to one beat count
   logic [CNT_W-1:0] beat_cnt;
   logic [CNT_W-1:0] cnt2;
   logic             v2;
   logic             last2;

   always_comb begin
      beat_cnt = '0;
      for (int g = 0; g < N_GRP; g++) begin
         beat_cnt = beat_cnt + CNT_W'(cnt1[g]);
      end
   end

   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         v2    <= 1'b0;
         last2 <= 1'b0;
         cnt2  <= '0;
      end else if (en) begin
         v2    <= v1;
         last2 <= last1;
         if (v1) cnt2 <= beat_cnt;
      end
   end

   // Stage 3: frame accumulation, one extra bit to detect overflow
   logic [ACC_W-1:0] acc;
   logic             first;
   logic [SUM_W-1:0] acc_base;
   logic [SUM_W-1:0] acc_next;
   logic [ACC_W-1:0] acc_upd;

   always_comb begin
      acc_base = first ? '0 : {1'b0, acc};
      acc_next = acc_base + SUM_W'(cnt2);
   end

`ifdef POPCNT_SAT_EN
   localparam logic [SUM_W-1:0] ACC_MAX = {1'b0, {ACC_W{1'b1}}};

   logic clamp;
   logic sat_flag;
   logic sat_upd;

   always_comb begin
      clamp   = acc_next > ACC_MAX;
      acc_upd = clamp ? {ACC_W{1'b1}} : acc_next[ACC_W-1:0];
      sat_upd = (!first && sat_flag) || clamp;
   end

   // Sticky per-frame clamp flag; ignored (restarted) by the first beat of a frame
   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         sat_flag  <= 1'b0;
         o_sum_sat <= 1'b0;
      end else if (en && v2) begin
         if (last2) begin
            o_sum_sat <= sat_upd;
            sat_flag  <= 1'b0;
         end else begin
            sat_flag  <= sat_upd;
         end
      end
   end
`else
   logic carry_unused;

   assign acc_upd      = acc_next[ACC_W-1:0];
   assign carry_unused = acc_next[ACC_W];
   assign o_sum_sat    = 1'b0;
`endif

   // With en high any pending result is being drained, so valid simply follows the load
   always_ff @(posedge s_clk or negedge s_rst_n) begin
      if (!s_rst_n) begin
         acc         <= '0;
         first       <= 1'b1;
         o_sum_valid <= 1'b0;
         o_sum       <= '0;
      end else if (en) begin
         if (v2 && last2) begin
            o_sum <= acc_upd;
            acc   <= '0;
            first <= 1'b1;
         end else if (v2) begin
            acc   <= acc_upd;
            first <= 1'b0;
         end
         o_sum_valid <= v2 && last2;
      end
   end

endmodule

// File: tb/tb_spike_popcount_accum.sv
// Scoreboard bench for spike_popcount_accum: directed frames, one default and one ACC_W=8 instance.
module tb_spike_popcount_accum;
   localparam int unsigned SPIKE_W = 64;
   localparam int unsigned ACC_W   = 16;
   localparam int unsigned ACC8_W  = 8;
   localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef struct {
      logic [15:0] sum;
      logic        sat;
   } exp_t;

   logic               s_clk = 1'b0;
   logic               s_rst_n = 1'b0;
   logic               valid, last, ready, sum_valid, sat, sum_ready;
   logic [SPIKE_W-1:0] data;
   logic [ACC_W-1:0]   sum;
   logic               valid8, last8, ready8, sum_valid8, sat8, sum_ready8;
   logic [SPIKE_W-1:0] data8;
   logic [ACC8_W-1:0]  sum8;

   exp_t q16[$];
   exp_t q8[$];
   int   n_checks = 0;
   int   n_fail = 0;
   bit   done = 1'b0;

   spike_popcount_accum #(.SPIKE_W(SPIKE_W), .ACC_W(ACC_W)) dut (
      .s_clk(s_clk), .s_rst_n(s_rst_n),
      .i_spikes_valid(valid), .i_spikes_data(data), .i_spikes_last(last),
      .o_spikes_ready(ready), .o_sum_valid(sum_valid), .o_sum(sum),
      .o_sum_sat(sat), .i_sum_ready(sum_ready)
   );

   spike_popcount_accum #(.SPIKE_W(SPIKE_W), .ACC_W(ACC8_W)) dut8 (
      .s_clk(s_clk), .s_rst_n(s_rst_n),
      .i_spikes_valid(valid8), .i_spikes_data(data8), .i_spikes_last(last8),
      .o_spikes_ready(ready8), .o_sum_valid(sum_valid8), .o_sum(sum8),
      .o_sum_sat(sat8), .i_sum_ready(sum_ready8)
   );

   always #5 s_clk = ~s_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, req);
      end
   endtask

   function automatic exp_t mk(input logic [15:0] s, input logic st);
      exp_t e;
      e.sum = s;
      e.sat = st;
      return e;
   endfunction

   // Drive a beat (we are just after a posedge) and hold it until accepted
   task automatic send(input logic [63:0] d, input logic l, output int waits);
      bit got = 1'b0;
      waits = 0;
      valid = 1'b1; data = d; last = l;
      for (int i = 0; i < 50; i++) begin
         @(negedge s_clk);
         if (ready) begin
            got = 1'b1;
            break;
         end
         waits++;
      end
      check("beat accepted within bound", 32'(got), 1);
      @(posedge s_clk); #1;
   endtask

   task automatic send8(input logic [63:0] d, input logic l);
      bit got = 1'b0;
      valid8 = 1'b1; data8 = d; last8 = l;
      for (int i = 0; i < 50; i++) begin
         @(negedge s_clk);
         if (ready8) begin
            got = 1'b1;
            break;
         end
      end
      check("dut8 beat accepted within bound", 32'(got), 1);
      @(posedge s_clk); #1;
   endtask

   task automatic idle();
      valid = 1'b0; last = 1'b0; data = '0;
   endtask

   task automatic wait_valid(input string name, output int cyc);
      cyc = 0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge s_clk);
         if (sum_valid) begin
            cyc = i;
            break;
         end
      end
      check({name, " result appeared"}, 32'(cyc != 0), 1);
   endtask

   task automatic drain();
      for (int i = 0; i < 80 && (q16.size() != 0 || q8.size() != 0); i++) @(negedge s_clk);
      check("dut16 results drained", 32'(q16.size()), 0);
      check("dut8 results drained", 32'(q8.size()), 0);
   endtask

   // Pops one expectation for every handshake on either output
   task automatic monitor();
      exp_t e;
      while (!done) begin
         @(negedge s_clk);
         if (sum_valid && sum_ready) begin
            n_checks++;
            if (q16.size() == 0) begin
               n_fail++;
               $display("FAIL dut16 unexpected result: got %0d, expected none", sum);
            end else begin
               e = q16.pop_front();
               check("dut16 o_sum", 32'(sum), 32'(e.sum));
               check("dut16 o_sum_sat", 32'(sat), 32'(e.sat));
            end
         end
         if (sum_valid8 && sum_ready8) begin
            n_checks++;
            if (q8.size() == 0) begin
               n_fail++;
               $display("FAIL dut8 unexpected result: got %0d, expected none", sum8);
            end else begin
               e = q8.pop_front();
               check("dut8 o_sum", 32'(sum8), 32'(e.sum));
               check("dut8 o_sum_sat", 32'(sat8), 32'(e.sat));
            end
         end
      end
   endtask

   task automatic stimulus();
      int w, wtot, cyc;

      // Reset state
      repeat (3) @(negedge s_clk);
      check("reset o_sum_valid", 32'(sum_valid), 0);
      check("reset o_sum", 32'(sum), 0);
      check("reset o_sum_sat", 32'(sat), 0);
      check("reset dut8 o_sum_valid", 32'(sum_valid8), 0);
      @(posedge s_clk); #1;
      s_rst_n = 1'b1;
      @(negedge s_clk);
      check("o_spikes_ready after reset", 32'(ready), 1);
      @(posedge s_clk); #1;

      // Single-beat frame: latency and one-cycle valid pulse
      q16.push_back(mk(16'd64, 1'b0));
      send(ONES, 1'b1, w);
      idle();
      wait_valid("single beat", cyc);
      check("single beat latency cycles", 32'(cyc), 3);
      check("single beat o_sum at valid", 32'(sum), 64);
      @(negedge s_clk);
      check("single beat valid one cycle", 32'(sum_valid), 0);
      @(posedge s_clk); #1;

      // Back-to-back 4-beat (97) and 2-beat (128) frames
      q16.push_back(mk(16'd97, 1'b0));
      q16.push_back(mk(16'd128, 1'b0));
      wtot = 0;
      send(64'h0F0F_0F0F_0F0F_0F0F, 1'b0, w); wtot += w;
      send(64'h1, 1'b0, w);                   wtot += w;
      send(64'h0, 1'b0, w);                   wtot += w;
      send(ONES, 1'b1, w);                    wtot += w;
      send(ONES, 1'b0, w);                    wtot += w;
      send(ONES, 1'b1, w);                    wtot += w;
      idle();
      check("back-to-back ready stalls", 32'(wtot), 0);
      drain();
      @(posedge s_clk); #1;

      // Two single-beat frames: second result loads while the first drains
      q16.push_back(mk(16'd7, 1'b0));
      q16.push_back(mk(16'd3, 1'b0));
      send(64'h7F, 1'b1, w);
      send(64'h07, 1'b1, w);
      idle();
      wait_valid("drain+load", cyc);
      check("drain+load first sum", 32'(sum), 7);
      @(negedge s_clk);
      check("drain+load valid stays high", 32'(sum_valid), 1);
      check("drain+load second sum", 32'(sum), 3);
      @(negedge s_clk);
      check("drain+load valid drops", 32'(sum_valid), 0);
      drain();
      @(posedge s_clk); #1;

      // Backpressure: downstream refuses for 10 cycles while beats keep coming
      sum_ready = 1'b0;
      q16.push_back(mk(16'd16, 1'b0));
      q16.push_back(mk(16'd2, 1'b0));
      q16.push_back(mk(16'd7, 1'b0));
      wtot = 0;
      fork
         begin
            send(64'hFF, 1'b0, w);   wtot += w;
            send(64'hFF00, 1'b1, w); wtot += w;
            send(64'h3, 1'b1, w);    wtot += w;
            send(64'hF, 1'b0, w);    wtot += w;
            send(64'h1, 1'b0, w);    wtot += w;
            send(64'h1, 1'b0, w);    wtot += w;
            send(64'h1, 1'b1, w);    wtot += w;
            idle();
         end
         begin
            wait_valid("stall", cyc);
            for (int i = 0; i < 10; i++) begin
               @(negedge s_clk);
               check("stall o_sum stable", 32'(sum), 16);
               check("stall o_sum_valid held", 32'(sum_valid), 1);
               check("stall o_spikes_ready low", 32'(ready), 0);
            end
            @(posedge s_clk); #1;
            sum_ready = 1'b1;
         end
      join
      check("stall blocked some beats", 32'(wtot > 0), 1);
      drain();
      @(posedge s_clk); #1;

      // Reset mid-frame: two beats of a partial frame must leave no residue
      send(ONES, 1'b0, w);
      send(ONES, 1'b0, w);
      idle();
      s_rst_n = 1'b0;
      @(negedge s_clk);
      check("mid-frame reset o_sum", 32'(sum), 0);
      check("mid-frame reset o_sum_valid", 32'(sum_valid), 0);
      @(posedge s_clk); #1;
      s_rst_n = 1'b1;
      q16.push_back(mk(16'd5, 1'b0));
      send(64'h1F, 1'b1, w);
      idle();
      drain();
      @(posedge s_clk); #1;

      // ACC_W=8 instance: 5 all-ones beats sum to 320
`ifdef POPCNT_SAT_EN
      q8.push_back(mk(16'd255, 1'b1));
`else
      q8.push_back(mk(16'd64, 1'b0));
`endif
      for (int i = 0; i < 5; i++) send8(ONES, i == 4);
      valid8 = 1'b0; last8 = 1'b0; data8 = '0;
      drain();
   endtask

   initial begin
      valid = 1'b0; last = 1'b0; data = '0; sum_ready = 1'b1;
      valid8 = 1'b0; last8 = 1'b0; data8 = '0; sum_ready8 = 1'b1;
      fork
         monitor();
         begin
            stimulus();
            done = 1'b1;
         end
      join
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
